rock_ramp_ctrl: RTL

ROCK_RAMP_CTRL -- requirements
Module: rock_ramp_ctrl

---
 rtl/rock_ramp_ctrl_if.sv | 21 ++
 rtl/rock_ramp_ctrl.sv | 128 ++++++++++++
 2 files changed

// File: rtl/rock_ramp_ctrl_if.sv
// rtl/rock_ramp_ctrl_if.sv - target request handshake between requester and rock_ramp_ctrl
interface rock_ramp_ctrl_if;
    logic       req_valid;
    logic [2:0] req_amp;
    logic [2:0] req_freq;
    logic       req_ready;

    modport master (
        output req_valid,
        output req_amp,
        output req_freq,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_amp,
        input  req_freq,
        output req_ready
    );
endinterface

// File: rtl/rock_ramp_ctrl.sv
// rtl/rock_ramp_ctrl.sv - rocking amplitude/frequency ramp and hold controller
// Optional safe stop input enabled by macro ROCK_SAFE_STOP_EN.
module rock_ramp_ctrl #(
    parameter int unsigned HOLD_TICKS = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tick,
`ifdef ROCK_SAFE_STOP_EN
    input  logic                   stop,
`endif
    rock_ramp_ctrl_if.slave        bus,
    output logic [2:0]             amp,
    output logic [2:0]             freq,
    output logic                   busy,
    output logic                   settled
);

    typedef enum logic [1:0] {IDLE, RAMP, HOLD} state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_TICKS);

    state_t     state, state_n;
    logic [2:0] tgt_amp, tgt_amp_n, tgt_freq, tgt_freq_n;
    logic [2:0] amp_n, freq_n, amp_step, freq_step, tgt_amp_eff;
    logic [7:0] hold_cnt, hold_cnt_n;
    logic       settled_n, stop_now, ready, accept;

    // Saturating single step; unsigned compare means 0 and 7 are hard limits.
    function automatic logic [2:0] step_toward(input logic [2:0] cur, input logic [2:0] tgt);
        if (tgt > cur)
            return cur + 3'd1;
        else if (tgt < cur)
            return cur - 3'd1;
        else
            return cur;
    endfunction

    always_comb begin
`ifdef ROCK_SAFE_STOP_EN
        stop_now = stop;
`else
        stop_now = 1'b0;
`endif
        ready       = (state != RAMP) && !stop_now;
        accept      = bus.req_valid && ready;
        tgt_amp_eff = stop_now ? 3'd0 : tgt_amp;
        amp_step    = step_toward(amp, tgt_amp_eff);
        freq_step   = step_toward(freq, tgt_freq);
    end

    assign bus.req_ready = ready;
    assign busy          = (state != IDLE);

    always_comb begin
        state_n    = state;
        amp_n      = amp;
        freq_n     = freq;
        tgt_amp_n  = stop_now ? 3'd0 : tgt_amp;
        tgt_freq_n = tgt_freq;
        hold_cnt_n = hold_cnt;
        settled_n  = 1'b0;

        if (stop_now && amp != 3'd0 && state != RAMP) begin
            state_n = RAMP;
        end else if (stop_now && amp == 3'd0) begin
            // Parked at zero amplitude: hold without counting down while stop persists.
            state_n = HOLD;
            if (state != HOLD)
                hold_cnt_n = HOLD_LOAD;
        end else if (accept) begin
            tgt_amp_n  = bus.req_amp;
            tgt_freq_n = bus.req_freq;
            if (bus.req_amp != amp || bus.req_freq != freq) begin
                state_n = RAMP;
            end else begin
                state_n    = HOLD;
                hold_cnt_n = HOLD_LOAD;
            end
        end else begin
            case (state)
                RAMP: begin
                    if (tick) begin
                        amp_n  = amp_step;
                        freq_n = freq_step;
                        if (amp_step == tgt_amp_eff && freq_step == tgt_freq) begin
                            state_n    = HOLD;
                            hold_cnt_n = HOLD_LOAD;
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        if (hold_cnt == 8'd1) begin
                            state_n    = IDLE;
                            hold_cnt_n = 8'd0;
                            settled_n  = 1'b1;
                        end else begin
                            hold_cnt_n = hold_cnt - 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            amp      <= 3'd0;
            freq     <= 3'd0;
            tgt_amp  <= 3'd0;
            tgt_freq <= 3'd0;
            hold_cnt <= 8'd0;
            settled  <= 1'b0;
        end else begin
            state    <= state_n;
            amp      <= amp_n;
            freq     <= freq_n;
            tgt_amp  <= tgt_amp_n;
            tgt_freq <= tgt_freq_n;
            hold_cnt <= hold_cnt_n;
            settled  <= settled_n;
        end
    end

endmodule
